regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper_pkg.sv | 25 ++
 rtl/regfile_dumper.sv | 103 ++++++++++
 tb/tb_regfile_dumper.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dumper_pkg.sv
// Shared CPU definitions: register-file geometry, MAU address helper and the
// dumper FSM state encoding.
package regfile_dumper_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_SHIFT = 2;
  localparam int IDX_W          = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [31:0]      data;
  } beat_t;

  // Word-aligned MAU byte address of a register index.
  function automatic logic [31:0] reg_addr(input logic [IDX_W-1:0] idx);
    return {{(32-IDX_W){1'b0}}, idx} << REG_ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/regfile_dumper.sv
// Walks NUM_REGS registers through the MAU read port while the CPU is halted
// and streams each (index, data) pair out over a valid/ready interface.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int BASE_INDEX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alive,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        mau_clk_en,
  output logic [31:0] mau_address,
  output logic        mau_wren,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(BASE_INDEX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BASE_INDEX + NUM_REGS - 1);

  logic [2:0]       state, state_nxt;
  logic [IDX_W-1:0] index;
  beat_t            beat_q;
  logic             out_valid_q, done_q, aborted_q;
  logic             handshake, abort, last_beat;

  assign handshake = out_valid_q & out_ready;
  assign last_beat = (index == LAST_IDX);
  // FINISH already reports a clean end, so alive there just returns to IDLE.
  assign abort     = alive & (state inside {ST_ISSUE, ST_CAPTURE, ST_SEND});

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start && !alive) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_SEND;
      ST_SEND:    if (handshake) state_nxt = last_beat ? ST_FINISH : ST_ISSUE;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (alive && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      index       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        ST_IDLE: if (start && !alive) index <= FIRST_IDX;
        ST_CAPTURE: begin
          beat_q      <= '{index: index, data: rf_data};
          out_valid_q <= 1'b1;
        end
        ST_SEND: if (handshake) begin
          out_valid_q <= 1'b0;
          if (last_beat) done_q <= !alive;
          else if (!alive) index <= index + 1'b1;
        end
        default: ;
      endcase
      // A handshake in the abort cycle is still consumed; the stream just stops.
      if (abort) begin
        out_valid_q <= 1'b0;
        done_q      <= 1'b1;
        aborted_q   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (NUM_REGS >= 1 && BASE_INDEX >= 0 && BASE_INDEX + NUM_REGS <= REG_COUNT)
      else $error("regfile_dumper: BASE_INDEX+NUM_REGS exceeds register file");
  end

  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign mau_clk_en  = (state == ST_ISSUE);
  // index only moves when heading into ISSUE, so the address holds otherwise.
  assign mau_address = reg_addr(index);
  assign mau_wren    = 1'b0;
  assign out_valid   = out_valid_q;
  assign out_data    = beat_q.data;
  assign out_index   = beat_q.index;

endmodule

// File: tb/tb_regfile_dumper.sv
// Randomized bench for regfile_dumper: two configurations, a register-file
// model on the MAU port and a queue-based model of the expected beat stream.
module tb_regfile_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, alive, start_drv, ready_drv, sel;
  logic start0, start1, ready0, ready1;
  assign start0 = start_drv & ~sel;
  assign start1 = start_drv & sel;
  assign ready0 = ready_drv & ~sel;
  assign ready1 = ready_drv & sel;

  logic        busy0, done0, ab0, ce0, wren0, ov0;
  logic [31:0] addr0, od0, rf0;
  logic [4:0]  oi0;
  logic        busy1, done1, ab1, ce1, wren1, ov1;
  logic [31:0] addr1, od1, rf1;
  logic [4:0]  oi1;

  logic [31:0] regs0 [32];
  logic [31:0] regs1 [32];

  regfile_dumper dut0 (
    .clk(clk), .reset(reset), .alive(alive), .start(start0),
    .busy(busy0), .done(done0), .aborted(ab0),
    .mau_clk_en(ce0), .mau_address(addr0), .mau_wren(wren0), .rf_data(rf0),
    .out_valid(ov0), .out_ready(ready0), .out_data(od0), .out_index(oi0)
  );

  regfile_dumper #(.NUM_REGS(4), .BASE_INDEX(28)) dut1 (
    .clk(clk), .reset(reset), .alive(alive), .start(start1),
    .busy(busy1), .done(done1), .aborted(ab1),
    .mau_clk_en(ce1), .mau_address(addr1), .mau_wren(wren1), .rf_data(rf1),
    .out_valid(ov1), .out_ready(ready1), .out_data(od1), .out_index(oi1)
  );

  // Register file with one-cycle read latency
  initial begin rf0 = '0; rf1 = '0; end
  always @(posedge clk) begin
    if (ce0) rf0 <= regs0[addr0[6:2]];
    if (ce1) rf1 <= regs1[addr1[6:2]];
  end

  logic        v_busy, v_done, v_ab, v_ce, v_wren, v_ov;
  logic [31:0] v_addr, v_od;
  logic [4:0]  v_oi;
  assign v_busy = sel ? busy1 : busy0;
  assign v_done = sel ? done1 : done0;
  assign v_ab   = sel ? ab1   : ab0;
  assign v_ce   = sel ? ce1   : ce0;
  assign v_wren = sel ? wren1 : wren0;
  assign v_ov   = sel ? ov1   : ov0;
  assign v_addr = sel ? addr1 : addr0;
  assign v_od   = sel ? od1   : od0;
  assign v_oi   = sel ? oi1   : oi0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, v_busy, 0);
    chk({tag, "_done"}, v_done, 0);
    chk({tag, "_aborted"}, v_ab, 0);
    chk({tag, "_valid"}, v_ov, 0);
    chk({tag, "_clk_en"}, v_ce, 0);
    chk({tag, "_addr"}, v_addr, 0);
    chk({tag, "_data"}, v_od, 0);
    chk({tag, "_index"}, 32'(v_oi), 0);
    chk({tag, "_wren"}, v_wren, 0);
  endtask

  function automatic logic [31:0] reg_val(input int idx);
    return sel ? regs1[idx] : regs0[idx];
  endfunction

  // One dump on the selected DUT. Expected stream: indices base..base+n-1
  // with the register contents, each issued once at address index*4.
  task automatic run_dump(input int n, input int base, input bit rnd_ready,
                          input int abort_after, input int restart_cyc);
    int  exp_q[$];
    int  iss_q[$];
    int  cyc, pulses, accepted, last_hs, late_pulses;
    bit  done_seen, ab_exp;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(base + i);
      iss_q.push_back(base + i);
    end
    ab_exp = (abort_after >= 0);
    cyc = 0; pulses = 0; accepted = 0; last_hs = -1; done_seen = 0;
    @(negedge clk);
    start_drv = 1'b1;
    ready_drv = 1'b0;
    while (cyc < 2000 && !done_seen) begin
      @(negedge clk);
      cyc++;
      start_drv = (cyc == restart_cyc);
      if (v_ce) begin
        pulses++;
        if (iss_q.size() > 0) begin
          chk("mau_addr", v_addr, 32'(iss_q[0]) * 4);
          void'(iss_q.pop_front());
        end else chk("extra_issue", pulses, n);
      end
      if (v_done) begin
        done_seen = 1'b1;
        chk("aborted", v_ab, ab_exp);
        chk("valid_at_done", v_ov, 0);
        chk("busy_at_done", v_busy, !ab_exp);
      end else begin
        if (v_ov) begin
          if (exp_q.size() > 0) begin
            chk("out_index", 32'(v_oi), exp_q[0]);
            chk("out_data", v_od, reg_val(exp_q[0]));
          end else chk("extra_beat", accepted + 1, n);
        end
        if (ab_exp && accepted == abort_after) alive = 1'b1;
        ready_drv = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (v_ov && ready_drv) begin
          accepted++;
          last_hs = cyc;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
    start_drv = 1'b0;
    ready_drv = 1'b0;
    chk("dump_done", done_seen, 1);
    if (!ab_exp) begin
      chk("beats_accepted", accepted, n);
      chk("mau_pulses", pulses, n);
      if (!rnd_ready) chk("last_hs_cycle", last_hs, 3 * n);
      @(negedge clk);
      chk("done_one_cycle", v_done, 0);
      chk("idle_after_done", v_busy, 0);
    end else begin
      late_pulses = 0;
      repeat (8) begin
        @(negedge clk);
        if (v_ce || v_ov || v_busy) late_pulses++;
      end
      chk("activity_after_abort", late_pulses, 0);
      alive = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset = 1'b1; alive = 1'b0; start_drv = 1'b0; ready_drv = 1'b0; sel = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs0[i] = 32'h1000_0000 + 32'(i);
      regs1[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    start_drv = 1'b1; alive = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset0");
    sel = 1'b1; #1;
    chk_zero_outputs("reset1");
    sel = 1'b0;
    start_drv = 1'b0; alive = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk_zero_outputs("post_reset");

    // Full ordered dump, ready held high
    run_dump(32, 0, 1'b0, -1, -1);

    // Random contents, random backpressure
    for (int i = 0; i < 32; i++) regs0[i] = $urandom;
    run_dump(32, 0, 1'b1, -1, -1);

    // start with alive=1 is ignored
    @(negedge clk);
    alive = 1'b1; start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    chk("start_alive_busy", v_busy, 0);
    chk("start_alive_done", v_done, 0);
    alive = 1'b0;
    @(negedge clk);
    chk("start_alive_idle", v_busy, 0);

    // start while busy does not restart the sequence
    run_dump(32, 0, 1'b1, -1, 20);

    // Abort after five accepted beats, then a clean dump
    run_dump(32, 0, 1'b0, 5, -1);
    run_dump(32, 0, 1'b1, -1, -1);

    // Top-of-file configuration
    sel = 1'b1;
    run_dump(4, 28, 1'b0, -1, -1);
    run_dump(4, 28, 1'b1, -1, -1);
    sel = 1'b0;

    // Reset while stalled in SEND
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    waited = 0;
    while (!v_ov && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_send", v_ov, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero_outputs("mid_reset");
    @(negedge clk);
    chk("no_done_after_reset", v_done, 0);
    run_dump(32, 0, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
